snn_stim_driver: RTL and testbench

Synthesizable transmitter for the SNN input protocol. A host preloads one pattern (two 6×6 images, one 3×3 kernel, one 2×2 weight) through a byte-wide load port. On `start`, the block streams the pattern to the SNN core with exact `in_valid`/`img`/`ker`/`weight` timing, then waits for the single-cycle `out_valid`/`out_data` response and returns it to the host. It sits between an on-chip host and `SNN`, and replaces the behavioural pattern on silicon/FPGA bring-up.

---
 rtl/snn_pkg.sv | 20 ++
 rtl/snn_stim_driver_if.sv | 22 ++
 rtl/snn_stim_buf.sv | 44 ++++
 rtl/snn_stim_driver.sv | 167 ++++++++++++++++
 tb/tb_snn_stim_driver.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN stimulus driver.
package snn_pkg;

  localparam int unsigned IMG_LEN = 72;
  localparam int unsigned KER_LEN = 9;
  localparam int unsigned W_LEN   = 4;
  localparam int unsigned N       = IMG_LEN + KER_LEN + W_LEN;
  localparam int unsigned TIMEOUT = 1000;

  localparam int unsigned PTR_W = 7;
  localparam int unsigned CNT_W = 10;

  typedef logic [7:0]       snn_byte_t;
  typedef logic [9:0]       snn_res_t;
  typedef logic [PTR_W-1:0] snn_ptr_t;
  typedef logic [CNT_W-1:0] snn_cnt_t;

  typedef enum logic [1:0] {LOAD, ARMED, SEND, WAIT} drv_state_t;

endpackage

// File: rtl/snn_stim_driver_if.sv
// Link between the stimulus driver (master) and the SNN core (slave).
interface snn_stim_driver_if;
  import snn_pkg::*;

  logic      in_valid;
  snn_byte_t img;
  snn_byte_t ker;
  snn_byte_t weight;
  logic      out_valid;
  snn_res_t  out_data;

  modport master (
    output in_valid, img, ker, weight,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, img, ker, weight,
    output out_valid, out_data
  );

endinterface

// File: rtl/snn_stim_buf.sv
// Pattern register file: one write port plus async img/ker/weight read taps at stream index k.
module snn_stim_buf
  import snn_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  snn_ptr_t  wr_ptr,
  input  snn_byte_t wr_data,
  input  snn_ptr_t  k,
  output snn_byte_t img,
  output snn_byte_t ker,
  output snn_byte_t weight
);

  snn_byte_t mem [N];
  snn_ptr_t  ker_idx;
  snn_ptr_t  w_idx;

  // Contents are not reset; a reload is required after reset anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign ker_idx = snn_ptr_t'(IMG_LEN) + k;
  assign w_idx   = snn_ptr_t'(IMG_LEN + KER_LEN) + k;

  always_comb begin
    img    = '0;
    ker    = '0;
    weight = '0;
    if (k < snn_ptr_t'(IMG_LEN)) begin
      img = mem[k];
    end
    if (k < snn_ptr_t'(KER_LEN)) begin
      ker = mem[ker_idx];
    end
    if (k < snn_ptr_t'(W_LEN)) begin
      weight = mem[w_idx];
    end
  end

endmodule

// File: rtl/snn_stim_driver.sv
// Loads one SNN pattern from the host, streams it on start and returns the single-cycle response.
module snn_stim_driver
  import snn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_valid,
  input  snn_byte_t  ld_data,
  output logic       ld_ready,
  input  logic       flush,
  input  logic       start,
  output logic       busy,
  snn_stim_driver_if.master snn,
  output logic       res_valid,
  output snn_res_t   res_data,
  output logic       timeout
);

  drv_state_t state_q, state_d;
  snn_ptr_t   ptr_q, ptr_d;
  snn_cnt_t   cnt_q, cnt_d;

  logic       ld_ready_q, ld_ready_d;
  logic       busy_q, busy_d;
  logic       in_valid_q, in_valid_d;
  snn_byte_t  img_q, img_d;
  snn_byte_t  ker_q, ker_d;
  snn_byte_t  weight_q, weight_d;
  logic       res_valid_q, res_valid_d;
  snn_res_t   res_data_q, res_data_d;
  logic       timeout_q, timeout_d;

  logic       buf_we;
  snn_ptr_t   tap_k;
  snn_byte_t  tap_img, tap_ker, tap_weight;

  // Outputs are registered, so the taps look one index ahead of the byte on the bus.
  assign tap_k = (state_q == SEND) ? ptr_q + snn_ptr_t'(1) : '0;

  snn_stim_buf u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_ptr  (ptr_q),
    .wr_data (ld_data),
    .k       (tap_k),
    .img     (tap_img),
    .ker     (tap_ker),
    .weight  (tap_weight)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    in_valid_d  = 1'b0;
    img_d       = '0;
    ker_d       = '0;
    weight_d    = '0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    timeout_d   = 1'b0;
    buf_we      = 1'b0;

    if (flush) begin
      state_d = LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (ld_valid) begin
            buf_we = 1'b1;
            if (ptr_q == snn_ptr_t'(N - 1)) begin
              state_d = ARMED;
              ptr_d   = '0;
            end else begin
              ptr_d = ptr_q + snn_ptr_t'(1);
            end
          end
        end
        ARMED: begin
          if (start) begin
            state_d    = SEND;
            ptr_d      = '0;
            in_valid_d = 1'b1;
            img_d      = tap_img;
            ker_d      = tap_ker;
            weight_d   = tap_weight;
          end
        end
        SEND: begin
          if (ptr_q == snn_ptr_t'(IMG_LEN - 1)) begin
            state_d = WAIT;
            ptr_d   = '0;
            cnt_d   = '0;
          end else begin
            ptr_d      = ptr_q + snn_ptr_t'(1);
            in_valid_d = 1'b1;
            img_d      = tap_img;
            ker_d      = tap_ker;
            weight_d   = tap_weight;
          end
        end
        WAIT: begin
          // A response on the final wait cycle beats the timeout.
          if (snn.out_valid) begin
            res_data_d  = snn.out_data;
            res_valid_d = 1'b1;
            state_d     = ARMED;
            cnt_d       = '0;
          end else if (cnt_q == snn_cnt_t'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = ARMED;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + snn_cnt_t'(1);
          end
        end
        default: state_d = LOAD;
      endcase
    end

    ld_ready_d = (state_d == LOAD);
    busy_d     = (state_d == SEND) || (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      ptr_q       <= '0;
      cnt_q       <= '0;
      ld_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      in_valid_q  <= 1'b0;
      img_q       <= '0;
      ker_q       <= '0;
      weight_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ld_ready_q  <= ld_ready_d;
      busy_q      <= busy_d;
      in_valid_q  <= in_valid_d;
      img_q       <= img_d;
      ker_q       <= ker_d;
      weight_q    <= weight_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ld_ready     = ld_ready_q;
  assign busy         = busy_q;
  assign snn.in_valid = in_valid_q;
  assign snn.img      = img_q;
  assign snn.ker      = ker_q;
  assign snn.weight   = weight_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_snn_stim_driver.sv
// Directed bench for snn_stim_driver: stream and response scoreboards fed by the stimulus sequence.
module tb_snn_stim_driver;
  import snn_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      ld_valid;
  snn_byte_t ld_data;
  logic      ld_ready;
  logic      flush;
  logic      start;
  logic      busy;
  logic      res_valid;
  snn_res_t  res_data;
  logic      timeout;

  snn_stim_driver_if snn_if ();

  snn_stim_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .flush     (flush),
    .start     (start),
    .busy      (busy),
    .snn       (snn_if),
    .res_valid (res_valid),
    .res_data  (res_data),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stream_cnt = 0;
  int last_iv_cyc = 0;
  int tout_cnt = 0;
  int tout_cyc = 0;
  int ld_ptr = 0;
  logic [23:0] sq [$];
  snn_res_t    eres [$];
  snn_byte_t   tb_mem [N];
  snn_res_t    res_model = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboards whenever the DUT presents data.
  always @(negedge clk) begin : mon
    logic [23:0] e;
    if (rst_n) begin
      if (snn_if.in_valid) begin
        stream_cnt  = stream_cnt + 1;
        last_iv_cyc = cyc;
        if (sq.size() == 0) begin
          check("unexpected_in_valid", 32'd1, 32'd0);
        end else begin
          e = sq.pop_front();
          check("stream_byte", {8'h0, snn_if.img, snn_if.ker, snn_if.weight}, {8'h0, e});
        end
      end else begin
        check("idle_zero", {8'h0, snn_if.img, snn_if.ker, snn_if.weight}, 32'd0);
      end
      if (res_valid) begin
        if (eres.size() == 0) begin
          check("unexpected_res_valid", 32'd1, 32'd0);
        end else begin
          check("res_scoreboard", 32'(res_data), 32'(eres.pop_front()));
        end
      end
      if (timeout) begin
        tout_cnt = tout_cnt + 1;
        tout_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      ld_valid       = 1'b1;
      ld_data        = 8'(base + i);
      tb_mem[ld_ptr] = ld_data;
      ld_ptr         = (ld_ptr == N - 1) ? 0 : ld_ptr + 1;
      step();
    end
    ld_valid = 1'b0;
  endtask

  task automatic push_stream();
    for (int k = 0; k < IMG_LEN; k++) begin
      sq.push_back({tb_mem[k],
                    (k < KER_LEN) ? tb_mem[IMG_LEN + k] : 8'h00,
                    (k < W_LEN) ? tb_mem[IMG_LEN + KER_LEN + k] : 8'h00});
    end
  endtask

  // Returns at the negedge of WAIT cycle 0 (first cycle with in_valid low after the stream).
  task automatic wait_end(output bit ok);
    bit seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (snn_if.in_valid) begin
        seen = 1'b1;
      end else if (seen) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // delay >= 0: SNN answers on WAIT cycle 'delay'; delay < 0: SNN stays silent.
  task automatic run_txn(input int delay, input snn_res_t data, input bit guard);
    int s0;
    int t0;
    bit ok;
    bit seen;
    push_stream();
    s0    = stream_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    if (guard) begin
      repeat (10) step();
      start              = 1'b1;
      snn_if.out_valid   = 1'b1;
      snn_if.out_data    = 10'h2AA;
      step();
      start              = 1'b0;
      snn_if.out_valid   = 1'b0;
    end
    wait_end(ok);
    check("stream_done", 32'(ok), 32'd1);
    check("stream_len", stream_cnt - s0, 32'd72);
    check("busy_in_wait", 32'(busy), 32'd1);
    if (delay < 0) begin
      t0   = tout_cnt;
      seen = 1'b0;
      for (int i = 0; i < 1100; i++) begin
        if (tout_cnt != t0) begin
          seen = 1'b1;
          break;
        end
        step();
      end
      check("timeout_seen", 32'(seen), 32'd1);
      // WAIT cycle 999 lands 1000 cycles after the last in_valid; the pulse is registered.
      check("timeout_latency", tout_cyc - last_iv_cyc, 32'd1001);
      check("timeout_res_kept", 32'(res_data), 32'(res_model));
      check("timeout_armed_ready", 32'(ld_ready), 32'd0);
      check("timeout_armed_busy", 32'(busy), 32'd0);
    end else begin
      repeat (delay) step();
      eres.push_back(data);
      res_model        = data;
      snn_if.out_valid = 1'b1;
      snn_if.out_data  = data;
      step();
      snn_if.out_valid = 1'b0;
      check("res_valid", 32'(res_valid), 32'd1);
      check("res_no_timeout", 32'(timeout), 32'd0);
      check("res_busy_low", 32'(busy), 32'd0);
      check("res_data", 32'(res_data), 32'(data));
      step();
      check("res_pulse_once", 32'(res_valid), 32'd0);
      check("res_hold", 32'(res_data), 32'(data));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s;
    rst_n            = 1'b0;
    ld_valid         = 1'b0;
    ld_data          = '0;
    flush            = 1'b0;
    start            = 1'b0;
    snn_if.out_valid = 1'b0;
    snn_if.out_data  = '0;
    repeat (2) step();
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_snn_side", {7'h0, snn_if.in_valid, snn_if.img, snn_if.ker, snn_if.weight}, 32'd0);
    check("rst_res", {20'h0, res_valid, timeout, res_data}, 32'd0);
    rst_n = 1'b1;
    step();

    // start with a partial buffer is ignored
    load(40, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("load_start_ignored", stream_cnt, 32'd0);
    check("load_still_ready", 32'(ld_ready), 32'd1);
    load(45, 41);
    check("armed_ready_low", 32'(ld_ready), 32'd0);

    // load and replay; the replay also carries start/out_valid during SEND
    run_txn(2, 10'h155, 1'b0);
    run_txn(5, 10'h0CC, 1'b1);

    // timeout, then the tie on the last wait cycle
    run_txn(-1, 10'h000, 1'b0);
    run_txn(999, 10'h3FF, 1'b0);

    // flush beats start
    flush = 1'b1;
    start = 1'b1;
    step();
    flush  = 1'b0;
    start  = 1'b0;
    ld_ptr = 0;
    check("flush_ready", 32'(ld_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_in_valid", 32'(snn_if.in_valid), 32'd0);
    check("flush_res_kept", 32'(res_data), 32'h3FF);
    s = stream_cnt;
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("flush_needs_reload", stream_cnt - s, 32'd0);
    load(N, 100);
    run_txn(0, 10'h001, 1'b0);

    // async reset during SEND cycle 30
    push_stream();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (30) step();
    rst_n = 1'b0;
    #1;
    check("arst_in_valid", 32'(snn_if.in_valid), 32'd0);
    check("arst_bus", {8'h0, snn_if.img, snn_if.ker, snn_if.weight}, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_res_data", 32'(res_data), 32'd0);
    sq.delete();
    res_model = '0;
    ld_ptr    = 0;
    step();
    rst_n = 1'b1;
    step();
    check("arst_ready_after", 32'(ld_ready), 32'd1);
    load(N, 7);
    run_txn(4, 10'h2B5, 1'b0);

    repeat (3) step();
    check("stream_queue_drained", sq.size(), 32'd0);
    check("res_queue_drained", eres.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
